multi_mode_time_counter: RTL and testbench
==========================================

MULTI_MODE_TIME_COUNTER -- requirements
Module: multi_mode_time_counter

Interface
REQ-001 Parameter W, default 6, bit width of each time field.
REQ-002 Parameter S_MAX, default 59, seconds field maximum.
REQ-003 Parameter M_MAX, default 59, minutes field maximum.
REQ-004 Parameter H_MAX, default 23, hours field maximum.
REQ-005 Port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-006 Port i_reset  input  1  asynchronous, active-low reset.
REQ-007 Port i_tick  input  1  one-cycle time-base enable pulse (1 Hz strobe).
REQ-008 Port i_mode  input  2  00 clock, 01 countdown timer, 10 stopwatch, 11 hold.
REQ-009 Port i_set  input  1  level; 1 = manual adjust active.
REQ-010 Port i_sel  input  2  adjust target: 00 sec, 01 min, 10 hour, 11 none.
REQ-011 Port i_up / i_down  input  1 each  raw level button inputs.
REQ-012 Port i_start  input  1  level start/stop button (rising edge used).
REQ-013 Port i_save / i_restore  input  1 each  level; snapshot store / reload.
REQ-014 Port o_h / o_m / o_s  output  W each  current hour/min/sec.
REQ-015 Port o_run  output  1  1 while countdown or stopwatch is running.
REQ-016 Port o_done  output  1  one-cycle pulse on countdown expiry.

Function
REQ-017 Rising edges of i_up, i_down, i_start SHALL be detected against a registered previous sample; the action takes effect on the same clock edge where current=1 and previous=0; a held level SHALL act exactly once.
REQ-018 Per-cycle priority SHALL be: i_restore > i_save > set adjust > tick counting.
REQ-019 i_restore=1 SHALL load o_h/o_m/o_s from the snapshot registers next edge and clear run; i_save=1 (restore=0) SHALL copy current fields into the snapshot registers, counts unchanged.
REQ-020 While i_set=1, i_tick SHALL be ignored and run forced to 0; up edge SHALL increment the selected field (MAX -> 0), down edge decrement (0 -> MAX); no out-of-range value SHALL ever appear on outputs; other fields unchanged, no carry/borrow.
REQ-021 Simultaneous up and down edges, or i_sel=11, SHALL leave fields unchanged.
REQ-022 Clock mode (00): each i_tick SHALL increment sec with carry into min and hour; H_MAX:M_MAX:S_MAX -> 0:0:0; o_run=0.
REQ-023 Run FSM states STOP, RUN; start edge in STOP -> RUN, in RUN -> STOP; o_run=1 exactly in RUN.
REQ-024 Stopwatch mode (10): in RUN, each i_tick SHALL increment with the same carry/wrap as clock mode.
REQ-025 Countdown mode (01): start edge while all fields are 0 SHALL be ignored (stay STOP); in RUN each i_tick SHALL decrement with borrow (sec 0 -> S_MAX, min borrows from hour, min 0 -> M_MAX).
REQ-026 Countdown tick at 0:0:1 SHALL yield 0:0:0, assert o_done for exactly one cycle (registered), and return FSM to STOP in the same edge.
REQ-027 Mode 11 SHALL freeze all fields and FSM; set, save, restore still act.
REQ-028 Any change of i_mode value SHALL force FSM to STOP; fields retained.
REQ-029 Parameters SHALL satisfy MAX < 2**W; fields SHALL never exceed their MAX.

Reset
REQ-030 i_reset=0 SHALL immediately clear fields, snapshot registers, edge-detect registers, FSM (STOP), o_run and o_done to 0, regardless of clock.
REQ-031 After release, first action SHALL occur on the first rising edge with i_reset=1; an input already high at release SHALL register as an edge.

Verification
REQ-032 Clock mode, set to 23:59:58, two i_tick pulses -> 00:00:00, o_done stays 0.
REQ-033 Set mode, sel=01, min=59, up edge -> min=0, hour unchanged; down edge at 0 -> 59; i_up held 10 cycles -> single step.
REQ-034 Countdown from 00:01:00, start edge, tick -> 00:00:59; run to 00:00:01, tick -> 00:00:00, o_done high 1 cycle, o_run=0.
REQ-035 Countdown at 00:00:00, start edge -> o_run stays 0, no o_done.
REQ-036 Save at 12:34:56, adjust to 01:00:00, save+restore together -> 12:34:56 next cycle, snapshot unchanged.
REQ-037 Stopwatch running at 00:00:10, i_reset low mid-cycle -> all outputs 0 before next clock edge, o_run=0.

Source files
------------

// File: rtl/multi_mode_time_counter.sv
// Hours/minutes/seconds counter with clock, countdown and stopwatch modes, manual
// adjust, and a snapshot save/restore register set.
module multi_mode_time_counter #(
  parameter int unsigned W     = 6,
  parameter int unsigned S_MAX = 59,
  parameter int unsigned M_MAX = 59,
  parameter int unsigned H_MAX = 23
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_tick,
  input  logic [1:0]   i_mode,
  input  logic         i_set,
  input  logic [1:0]   i_sel,
  input  logic         i_up,
  input  logic         i_down,
  input  logic         i_start,
  input  logic         i_save,
  input  logic         i_restore,
  output logic [W-1:0] o_h,
  output logic [W-1:0] o_m,
  output logic [W-1:0] o_s,
  output logic         o_run,
  output logic         o_done
);

  typedef enum logic {StStop, StRun} run_state_e;

  localparam logic [W-1:0] SMax = W'(S_MAX);
  localparam logic [W-1:0] MMax = W'(M_MAX);
  localparam logic [W-1:0] HMax = W'(H_MAX);
  localparam logic [W-1:0] One  = W'(1);

  logic [W-1:0] h_q, h_d, m_q, m_d, s_q, s_d;
  logic [W-1:0] snap_h_q, snap_h_d, snap_m_q, snap_m_d, snap_s_q, snap_s_d;
  logic         up_q, down_q, start_q;
  logic [1:0]   mode_q;
  logic         done_q, done_d;
  run_state_e   state_q, state_d;

  logic         up_edge, down_edge, start_edge, mode_chg, is_zero, run_ok, expire;
  logic [W-1:0] s_up, s_dn, m_up, m_dn, h_up, h_dn;
  logic [W-1:0] inc_h, inc_m, inc_s, dec_h, dec_m, dec_s;

  assign up_edge    = i_up & ~up_q;
  assign down_edge  = i_down & ~down_q;
  assign start_edge = i_start & ~start_q;
  assign mode_chg   = (i_mode != mode_q);
  assign is_zero    = (h_q == '0) && (m_q == '0) && (s_q == '0);
  assign run_ok     = (state_q == StRun) && !mode_chg;

  // Per-field wrap steps, shared by manual adjust and the carry/borrow chains.
  assign s_up = (s_q == SMax) ? '0 : s_q + One;
  assign s_dn = (s_q == '0) ? SMax : s_q - One;
  assign m_up = (m_q == MMax) ? '0 : m_q + One;
  assign m_dn = (m_q == '0) ? MMax : m_q - One;
  assign h_up = (h_q == HMax) ? '0 : h_q + One;
  assign h_dn = (h_q == '0) ? HMax : h_q - One;

  assign inc_s = s_up;
  assign inc_m = (s_q == SMax) ? m_up : m_q;
  assign inc_h = ((s_q == SMax) && (m_q == MMax)) ? h_up : h_q;
  assign dec_s = s_dn;
  assign dec_m = (s_q == '0) ? m_dn : m_q;
  assign dec_h = ((s_q == '0) && (m_q == '0)) ? h_dn : h_q;

  always_comb begin
    h_d      = h_q;
    m_d      = m_q;
    s_d      = s_q;
    snap_h_d = snap_h_q;
    snap_m_d = snap_m_q;
    snap_s_d = snap_s_q;
    state_d  = state_q;
    done_d   = 1'b0;
    expire   = 1'b0;

    if (i_restore) begin
      h_d     = snap_h_q;
      m_d     = snap_m_q;
      s_d     = snap_s_q;
      state_d = StStop;
    end else if (i_save) begin
      snap_h_d = h_q;
      snap_m_d = m_q;
      snap_s_d = s_q;
    end else if (i_set) begin
      state_d = StStop;
      if (up_edge ^ down_edge) begin
        unique case (i_sel)
          2'b00:   s_d = up_edge ? s_up : s_dn;
          2'b01:   m_d = up_edge ? m_up : m_dn;
          2'b10:   h_d = up_edge ? h_up : h_dn;
          2'b11:   ;
        endcase
      end
    end else if (i_mode != 2'b11) begin
      unique case (i_mode)
        2'b00: if (i_tick) begin
          h_d = inc_h; m_d = inc_m; s_d = inc_s;
        end
        2'b01: if (run_ok && i_tick && !is_zero) begin
          h_d = dec_h; m_d = dec_m; s_d = dec_s;
          if ((h_q == '0) && (m_q == '0) && (s_q == One)) begin
            done_d  = 1'b1;
            expire  = 1'b1;
            state_d = StStop;
          end
        end
        2'b10: if (run_ok && i_tick) begin
          h_d = inc_h; m_d = inc_m; s_d = inc_s;
        end
        2'b11: ;
      endcase
      // Start only toggles the run FSM in countdown and stopwatch modes.
      if (start_edge && (i_mode[0] ^ i_mode[1]) && !expire) begin
        if (state_q == StRun) begin
          state_d = StStop;
        end else if (i_mode == 2'b10 || !is_zero) begin
          state_d = StRun;
        end
      end
    end

    if (mode_chg) state_d = StStop;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      h_q      <= '0;
      m_q      <= '0;
      s_q      <= '0;
      snap_h_q <= '0;
      snap_m_q <= '0;
      snap_s_q <= '0;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      start_q  <= 1'b0;
      mode_q   <= 2'b00;
      done_q   <= 1'b0;
      state_q  <= StStop;
    end else begin
      h_q      <= h_d;
      m_q      <= m_d;
      s_q      <= s_d;
      snap_h_q <= snap_h_d;
      snap_m_q <= snap_m_d;
      snap_s_q <= snap_s_d;
      up_q     <= i_up;
      down_q   <= i_down;
      start_q  <= i_start;
      mode_q   <= i_mode;
      done_q   <= done_d;
      state_q  <= state_d;
    end
  end

  assign o_h    = h_q;
  assign o_m    = m_q;
  assign o_s    = s_q;
  assign o_run  = (state_q == StRun);
  assign o_done = done_q;

endmodule

// File: tb/tb_multi_mode_time_counter.sv
// Randomized and directed bench for multi_mode_time_counter against a
// total-seconds reference model.
module tb_multi_mode_time_counter;

  localparam int unsigned W     = 6;
  localparam int unsigned S_MAX = 59;
  localparam int unsigned M_MAX = 59;
  localparam int unsigned H_MAX = 23;
  localparam int SPAN = (H_MAX + 1) * (M_MAX + 1) * (S_MAX + 1);

  logic         i_clk = 1'b0;
  logic         i_reset = 1'b0;
  logic         i_tick = 1'b0, i_set = 1'b0, i_up = 1'b0, i_down = 1'b0;
  logic         i_start = 1'b0, i_save = 1'b0, i_restore = 1'b0;
  logic [1:0]   i_mode = 2'b00, i_sel = 2'b00;
  logic [W-1:0] o_h, o_m, o_s;
  logic         o_run, o_done;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int mh, mm, ms, sh, sm, ss;
  bit mrun, mdone, pu, pd, pst;
  logic [1:0] pmode;

  multi_mode_time_counter #(.W(W), .S_MAX(S_MAX), .M_MAX(M_MAX), .H_MAX(H_MAX)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_tick(i_tick), .i_mode(i_mode), .i_set(i_set),
    .i_sel(i_sel), .i_up(i_up), .i_down(i_down), .i_start(i_start), .i_save(i_save),
    .i_restore(i_restore), .o_h(o_h), .o_m(o_m), .o_s(o_s), .o_run(o_run), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int tot();
    return (mh * (M_MAX + 1) + mm) * (S_MAX + 1) + ms;
  endfunction

  task automatic from_tot(input int t);
    ms = t % (S_MAX + 1);
    t  = t / (S_MAX + 1);
    mm = t % (M_MAX + 1);
    mh = t / (M_MAX + 1);
  endtask

  function automatic int adj(input int v, input int mx, input bit up);
    if (up) return (v == mx) ? 0 : v + 1;
    return (v == 0) ? mx : v - 1;
  endfunction

  task automatic model_reset();
    mh = 0; mm = 0; ms = 0; sh = 0; sm = 0; ss = 0;
    mrun = 0; mdone = 0; pu = 0; pd = 0; pst = 0; pmode = 2'b00;
  endtask

  task automatic model_clk();
    bit upe, dne, ste, chg, expired;
    upe = i_up && !pu;
    dne = i_down && !pd;
    ste = i_start && !pst;
    chg = (i_mode != pmode);
    expired = 0;
    mdone = 0;
    if (i_restore) begin
      mh = sh; mm = sm; ms = ss; mrun = 0;
    end else if (i_save) begin
      sh = mh; sm = mm; ss = ms;
    end else if (i_set) begin
      mrun = 0;
      if (upe != dne) begin
        case (i_sel)
          2'd0: ms = adj(ms, S_MAX, upe);
          2'd1: mm = adj(mm, M_MAX, upe);
          2'd2: mh = adj(mh, H_MAX, upe);
          default: ;
        endcase
      end
    end else if (i_mode != 2'd3) begin
      bit was_zero;
      was_zero = (tot() == 0);
      if (i_tick) begin
        if (i_mode == 2'd0 || (i_mode == 2'd2 && mrun && !chg)) from_tot((tot() + 1) % SPAN);
        else if (i_mode == 2'd1 && mrun && !chg && !was_zero) begin
          from_tot(tot() - 1);
          if (tot() == 0) begin
            mdone = 1; mrun = 0; expired = 1;
          end
        end
      end
      if (ste && (i_mode == 2'd1 || i_mode == 2'd2) && !expired) begin
        if (mrun) mrun = 0;
        else if (i_mode == 2'd2 || !was_zero) mrun = 1;
      end
    end
    if (chg) mrun = 0;
    pu = i_up; pd = i_down; pst = i_start; pmode = i_mode;
  endtask

  task automatic cyc();
    @(posedge i_clk);
    model_clk();
    #1;
    check_eq("state", {12'd0, o_h, o_m, o_s, o_run, o_done},
             {12'd0, 6'(mh), 6'(mm), 6'(ms), mrun, mdone});
  endtask

  task automatic set_field(input logic [1:0] sel, input int target);
    int cur;
    i_set = 1'b1;
    i_sel = sel;
    for (int k = 0; k < 70; k++) begin
      cur = (sel == 2'd0) ? ms : (sel == 2'd1) ? mm : mh;
      if (cur == target) break;
      i_up = 1'b1; cyc();
      i_up = 1'b0; cyc();
    end
    i_set = 1'b0;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    set_field(2'd2, h);
    set_field(2'd1, m);
    set_field(2'd0, s);
  endtask

  initial begin
    model_reset();
    #1;
    check_eq("reset", {o_h, o_m, o_s, o_run, o_done}, '0);
    #11 i_reset = 1'b1;

    // Clock wrap at end of day
    set_time(23, 59, 58);
    for (int k = 0; k < 2; k++) begin
      i_tick = 1'b1; cyc();
      i_tick = 1'b0; cyc();
    end
    check_eq("clk_wrap", {o_h, o_m, o_s}, '0);
    check_eq("clk_nodone", o_done, 0);

    // Manual adjust: wrap without carry, held button steps once
    set_field(2'd1, 59);
    i_set = 1'b1; i_sel = 2'd1;
    i_up = 1'b1; cyc(); i_up = 1'b0; cyc();
    check_eq("set_up_wrap", o_m, 0);
    check_eq("set_no_carry", o_h, 0);
    i_down = 1'b1; cyc(); i_down = 1'b0; cyc();
    check_eq("set_dn_wrap", o_m, 59);
    i_up = 1'b1;
    for (int k = 0; k < 10; k++) cyc();
    i_up = 1'b0; cyc();
    check_eq("set_held_once", o_m, 0);
    i_up = 1'b1; i_down = 1'b1; cyc(); i_up = 1'b0; i_down = 1'b0; cyc();
    check_eq("set_both", o_m, 0);
    i_set = 1'b0;

    // Countdown to expiry
    i_mode = 2'd1;
    set_time(0, 1, 0);
    i_start = 1'b1; cyc(); i_start = 1'b0; cyc();
    check_eq("cd_run", o_run, 1);
    i_tick = 1'b1; cyc(); i_tick = 1'b0; cyc();
    check_eq("cd_borrow", {o_h, o_m, o_s}, {6'd0, 6'd0, 6'd59});
    i_tick = 1'b1;
    for (int k = 0; k < 58; k++) cyc();
    check_eq("cd_one", {o_h, o_m, o_s}, {6'd0, 6'd0, 6'd1});
    cyc();
    check_eq("cd_zero", {o_h, o_m, o_s}, '0);
    check_eq("cd_done", o_done, 1);
    check_eq("cd_stop", o_run, 0);
    i_tick = 1'b0; cyc();
    check_eq("cd_done_pulse", o_done, 0);

    // Start at zero is ignored
    i_start = 1'b1; cyc();
    check_eq("cd_zero_start", {o_run, o_done}, 0);
    i_start = 1'b0; cyc();

    // Snapshot save/restore
    set_time(12, 34, 56);
    i_save = 1'b1; cyc(); i_save = 1'b0;
    set_time(1, 0, 0);
    i_save = 1'b1; i_restore = 1'b1; cyc();
    i_save = 1'b0; i_restore = 1'b0;
    check_eq("restore", {o_h, o_m, o_s}, {6'd12, 6'd34, 6'd56});
    set_time(3, 3, 3);
    i_restore = 1'b1; cyc(); i_restore = 1'b0;
    check_eq("snap_kept", {o_h, o_m, o_s}, {6'd12, 6'd34, 6'd56});

    // Stopwatch, then asynchronous reset mid-cycle
    i_mode = 2'd2;
    set_time(0, 0, 9);
    i_start = 1'b1; cyc(); i_start = 1'b0;
    i_tick = 1'b1; cyc(); i_tick = 1'b0; cyc();
    check_eq("sw_run", {o_h, o_m, o_s, o_run}, {6'd0, 6'd0, 6'd10, 1'b1});
    #2 i_reset = 1'b0;
    #1;
    check_eq("rst_async", {o_h, o_m, o_s, o_run, o_done}, '0);
    model_reset();
    #1 i_reset = 1'b1;

    // Randomized phase against the model
    for (int n = 0; n < 3000; n++) begin
      i_tick    = 1'($urandom_range(0, 1));
      i_up      = ($urandom_range(0, 3) == 0);
      i_down    = ($urandom_range(0, 3) == 0);
      i_start   = ($urandom_range(0, 5) == 0);
      i_set     = ($urandom_range(0, 7) == 0);
      i_sel     = 2'($urandom_range(0, 3));
      i_save    = ($urandom_range(0, 31) == 0);
      i_restore = ($urandom_range(0, 47) == 0);
      if ($urandom_range(0, 59) == 0) i_mode = 2'($urandom_range(0, 3));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
